// File: rtl/fp_sequencer.sv
// fp_sequencer: control FSM for the shared single-precision add/multiply
// datapath. Walks one request through exponent compare, alignment, mantissa
// compute, normalisation, rounding and an optional single renormalise pass,
// then pulses done. Only exponent fields and datapath status are observed;
// operands go straight from the requester to the datapath.
module fp_sequencer #(
  parameter int MUL_CYCLES = 27
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op_in,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic [7:0]  exp_dif,
  input  logic [26:0] ula,
  input  logic [25:0] round_fract,
  output logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic        zero,
  output logic        start,
  output logic        mult_reset,
  output logic        sinal_mux_fp1,
  output logic        sinal_mux_fp2,
  output logic        sinal_mux_fp3,
  output logic        sinal_mux_fp4,
  output logic        sinal_mux_fp5,
  output logic [7:0]  sinal_shift_fract,
  output logic [8:0]  sinal_shift_res,
  output logic [8:0]  sinal_inc_or_dec,
  output logic        sinal_round
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_EXP,
    S_ALIGN,
    S_MUL_RST,
    S_MUL_RUN,
    S_NORM,
    S_ROUND,
    S_RENORM,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic        a_big;
  logic        nz;

  logic [4:0]  lead;
  logic [4:0]  norm_n;
  logic [26:0] shifted;
  logic        norm_nz;
  logic        ula_zero;
  logic [7:0]  shift_sat;
  logic        unused_bits;

  // Leading-one position of the mantissa result (highest set bit wins).
  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (ula[i]) lead = i[4:0];
    end
  end

  assign ula_zero  = (ula == 27'd0);
  assign norm_n    = 5'd26 - lead;
  assign shifted   = ula << norm_n;
  // Sticky "anything below the hidden bit" after normalisation; used to
  // recognise a rounding carry that wrapped the mantissa to zero.
  assign norm_nz   = |shifted[25:1];
  // Shifting further than the mantissa width only drains it, so cap at 27.
  assign shift_sat = (exp_dif > 8'd27) ? 8'd27 : exp_dif;

  // Guard/round/sticky bits and the shifted-out ends are not needed here.
  assign unused_bits = &{1'b0, round_fract[2:0], shifted[26], shifted[0]};

  // State register plus per-operation bookkeeping (op, a_big, zero, nz, counter).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op    <= 2'b00;
      a_big <= 1'b0;
      zero  <= 1'b0;
      nz    <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (req) begin
            op    <= (op_in == 2'b00) ? 2'b00 : 2'b01;
            a_big <= (exp_a >= exp_b);
            zero  <= 1'b0;
          end
        end
        S_MUL_RST: cnt <= MUL_CYCLES[7:0];
        S_MUL_RUN: cnt <= cnt - 8'd1;
        S_NORM: begin
          nz <= norm_nz;
          if (ula_zero) zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and Moore control decode (NORM shift/adjust follow ula directly).
  always_comb begin
    state_next        = state;
    busy              = 1'b1;
    done              = 1'b0;
    start             = 1'b0;
    mult_reset        = 1'b0;
    sinal_mux_fp1     = 1'b0;
    sinal_mux_fp2     = 1'b0;
    sinal_mux_fp3     = 1'b0;
    sinal_mux_fp4     = 1'b0;
    sinal_mux_fp5     = 1'b0;
    sinal_shift_fract = 8'd0;
    sinal_shift_res   = 9'd0;
    sinal_inc_or_dec  = 9'd0;
    sinal_round       = 1'b0;

    // Alignment selects stay put from ALIGN through NORM for an add.
    if ((state == S_ALIGN || state == S_NORM) && op == 2'b00) begin
      sinal_mux_fp1     = ~a_big;
      sinal_mux_fp2     = ~a_big;
      sinal_mux_fp3     = a_big;
      sinal_shift_fract = shift_sat;
    end

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) state_next = (op_in == 2'b00) ? S_EXP : S_MUL_RST;
      end
      S_EXP:   state_next = S_ALIGN;
      S_ALIGN: state_next = S_NORM;
      S_MUL_RST: begin
        mult_reset = 1'b1;
        start      = 1'b1;
        state_next = S_MUL_RUN;
      end
      S_MUL_RUN: begin
        if (cnt == 8'd0) state_next = S_NORM;
      end
      S_NORM: begin
        if (ula_zero) begin
          state_next = S_DONE;
        end else begin
          sinal_round = 1'b1;
          if (norm_n != 5'd0) begin
            sinal_shift_res  = {1'b1, 3'b000, norm_n};
            sinal_inc_or_dec = {1'b1, 3'b000, norm_n};
          end
          state_next = S_ROUND;
        end
      end
      S_ROUND: begin
        if (round_fract[25:3] == 23'd0 && nz) state_next = S_RENORM;
        else state_next = S_DONE;
      end
      S_RENORM: begin
        sinal_mux_fp4    = 1'b1;
        sinal_mux_fp5    = 1'b1;
        sinal_shift_res  = 9'h001;
        sinal_inc_or_dec = 9'h001;
        sinal_round      = 1'b1;
        state_next       = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_sequencer.sv
// tb_fp_sequencer: directed bench for fp_sequencer. Plays the datapath by
// driving exp_dif, ula and round_fract at the right cycles and checks the
// control outputs cycle by cycle against hand-computed values.
module tb_fp_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic [1:0]  op_in;
  logic [7:0]  exp_a, exp_b, exp_dif;
  logic [26:0] ula;
  logic [25:0] round_fract;
  logic [1:0]  op;
  logic        busy, done, zero, start, mult_reset;
  logic        fp1, fp2, fp3, fp4, fp5;
  logic [7:0]  shift_fract;
  logic [8:0]  shift_res, inc_dec;
  logic        rnd;

  int errors = 0;
  int checks = 0;
  int dones  = 0;

  fp_sequencer #(.MUL_CYCLES(27)) dut (
    .clock(clock), .reset(reset), .req(req), .op_in(op_in),
    .exp_a(exp_a), .exp_b(exp_b), .exp_dif(exp_dif), .ula(ula),
    .round_fract(round_fract), .op(op), .busy(busy), .done(done),
    .zero(zero), .start(start), .mult_reset(mult_reset),
    .sinal_mux_fp1(fp1), .sinal_mux_fp2(fp2), .sinal_mux_fp3(fp3),
    .sinal_mux_fp4(fp4), .sinal_mux_fp5(fp5),
    .sinal_shift_fract(shift_fract), .sinal_shift_res(shift_res),
    .sinal_inc_or_dec(inc_dec), .sinal_round(rnd)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; op_in = 2'b00;
    exp_a = 8'd0; exp_b = 8'd0; exp_dif = 8'd0;
    ula = 27'd0; round_fract = 26'd0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 0);
    chk("rst_op", op, 0);
    chk("rst_start", start, 0);
    reset = 1'b0;
    tick();

    // 1.5 + 2.25: B is bigger, shift A right by 1, no normalise shift.
    exp_a = 8'd127; exp_b = 8'd128; exp_dif = 8'd1; op_in = 2'b00; req = 1'b1;
    tick(); req = 1'b0;                                   // k+1 EXP
    chk("add1_exp_busy", busy, 1);
    chk("add1_exp_op", op, 0);
    tick();                                               // k+2 ALIGN
    chk("add1_fp1", fp1, 1);
    chk("add1_fp2", fp2, 1);
    chk("add1_fp3", fp3, 0);
    chk("add1_shift_fract", shift_fract, 1);
    ula = 27'h7800000; round_fract = 26'h3C00000;
    tick();                                               // k+3 NORM
    chk("add1_norm_shift_res", shift_res, 9'h000);
    chk("add1_norm_round", rnd, 1);
    chk("add1_norm_fp3_held", fp3, 0);
    tick();                                               // k+4 ROUND
    chk("add1_round_done", done, 0);
    chk("add1_round_rnd", rnd, 0);
    tick();                                               // k+5 DONE
    chk("add1_done", done, 1);
    tick();
    chk("add1_idle_busy", busy, 0);
    chk("add1_idle_done", done, 0);
    $display("txn add 1.5+2.25 done at k+5");

    // 3.0 + (-3.0): tie selects A, zero mantissa skips rounding.
    exp_a = 8'd128; exp_b = 8'd128; exp_dif = 8'd0; req = 1'b1;
    tick(); req = 1'b0;
    tick();                                               // ALIGN
    chk("zero_tie_fp3", fp3, 1);
    chk("zero_tie_fp1", fp1, 0);
    ula = 27'd0;
    tick();                                               // NORM
    chk("zero_norm_round", rnd, 0);
    tick();                                               // k+4 DONE
    chk("zero_done", done, 1);
    chk("zero_flag", zero, 1);
    tick();
    chk("zero_held", zero, 1);
    chk("zero_idle_busy", busy, 0);
    $display("txn add 3.0-3.0 zero done at k+4");

    // 2.0 x 3.0: 28 iteration cycles, normalise by 3.
    op_in = 2'b11; req = 1'b1;
    tick(); req = 1'b0;                                   // k+1 MUL_RST
    chk("mul_mult_reset", mult_reset, 1);
    chk("mul_start", start, 1);
    chk("mul_op", op, 1);
    chk("mul_zero_cleared", zero, 0);
    for (int i = 2; i <= 29; i++) begin
      tick();
      chk("mul_run_start", start, 0);
      chk("mul_run_mreset", mult_reset, 0);
      chk("mul_run_busy", busy, 1);
      chk("mul_run_done", done, 0);
    end
    ula = 27'h0C00000; round_fract = 26'h1000000;
    tick();                                               // k+30 NORM
    chk("mul_norm_shift_res", shift_res, 9'h103);
    chk("mul_norm_inc_dec", inc_dec, 9'h103);
    chk("mul_norm_round", rnd, 1);
    tick();                                               // k+31 ROUND
    chk("mul_round_shift_res", shift_res, 9'h000);
    chk("mul_round_done", done, 0);
    tick();                                               // k+32 DONE
    chk("mul_done", done, 1);
    chk("mul_done_busy", busy, 1);
    tick();
    chk("mul_idle_busy", busy, 0);
    $display("txn mul 2.0x3.0 done at k+32");

    // 0x3FFFFFFF + 0x33800000: rounding wraps, one renormalise pass.
    exp_a = 8'd127; exp_b = 8'd103; exp_dif = 8'd24; op_in = 2'b00; req = 1'b1;
    tick(); req = 1'b0;
    tick();                                               // ALIGN
    chk("ren_fp1", fp1, 0);
    chk("ren_fp3", fp3, 1);
    chk("ren_shift_fract", shift_fract, 24);
    ula = 27'h7FFFFFF; round_fract = 26'd0;
    tick();                                               // NORM
    tick();                                               // ROUND
    chk("ren_round_done", done, 0);
    tick();                                               // k+5 RENORM
    chk("ren_fp4", fp4, 1);
    chk("ren_fp5", fp5, 1);
    chk("ren_shift_res", shift_res, 9'h001);
    chk("ren_inc_dec", inc_dec, 9'h001);
    chk("ren_round", rnd, 1);
    chk("ren_not_done", done, 0);
    tick();                                               // k+6 DONE
    chk("ren_done", done, 1);
    tick();
    $display("txn add renorm done at k+6");

    // exp_dif=40 saturates; req pulse in ALIGN is ignored; nz=0 avoids RENORM.
    exp_a = 8'd200; exp_b = 8'd160; exp_dif = 8'd40; req = 1'b1;
    tick(); req = 1'b0;
    tick();                                               // ALIGN
    chk("sat_shift_fract", shift_fract, 27);
    chk("sat_fp3", fp3, 1);
    req = 1'b1; ula = 27'h4000000; round_fract = 26'd0;
    tick(); req = 1'b0;                                   // NORM
    tick();                                               // ROUND
    tick();                                               // k+5 DONE
    chk("sat_done", done, 1);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dones++;
    end
    chk("sat_single_done", dones, 0);
    chk("sat_idle_busy", busy, 0);
    $display("txn add sat/ignored req done at k+5");

    // Reset in MUL_RUN: async clear, no done, then a clean add.
    op_in = 2'b01; req = 1'b1;
    tick(); req = 1'b0;
    for (int i = 2; i <= 10; i++) tick();
    chk("abort_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_op", op, 0);
    chk("abort_done", done, 0);
    chk("abort_start", start, 0);
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    exp_a = 8'd127; exp_b = 8'd128; exp_dif = 8'd1; op_in = 2'b00; req = 1'b1;
    tick(); req = 1'b0;
    tick();
    ula = 27'h7800000; round_fract = 26'h3C00000;
    tick(); tick();
    chk("post_rst_not_done", done, 0);
    tick();
    chk("post_rst_done", done, 1);
    $display("txn reset abort then add done at k+5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
